// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - ID-stage hazard scoreboard, operand forwarding selects and load-use stall
module id_hazard_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_reg1_raddr,
    input  logic [REG_ADDR_WIDTH-1:0] id_reg2_raddr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_reg_waddr,
    input  logic                      id_reg_we,
    input  logic                      id_is_load,
    input  logic                      ex_redirect,
    input  logic                      mem_busy,
    output logic [1:0]                fwd1_sel,
    output logic [1:0]                fwd2_sel,
    output logic                      load_use_stall,
    output logic                      idex_bubble,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = '0;
    localparam logic [CNT_WIDTH-1:0]      CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Scoreboard slot for the instruction currently in EX
    logic                      r_ex_valid;
    logic [REG_ADDR_WIDTH-1:0] r_ex_waddr;
    logic                      r_ex_we;
    logic                      r_ex_is_load;

    // Scoreboard slot for the instruction currently in MEM
    logic                      r_mem_valid;
    logic [REG_ADDR_WIDTH-1:0] r_mem_waddr;
    logic                      r_mem_we;

    logic [CNT_WIDTH-1:0]      r_stall_cnt;

    logic w_ex_writes;
    logic w_mem_writes;
    logic w_ex_hit1;
    logic w_ex_hit2;
    logic w_mem_hit1;
    logic w_mem_hit2;
    logic w_stall;
    logic w_bubble;

    // Hit detection: a slot only matters if it will really write a non-x0 register
    always_comb begin
        w_ex_writes  = r_ex_valid  & r_ex_we  & (r_ex_waddr  != ZERO_ADDR);
        w_mem_writes = r_mem_valid & r_mem_we & (r_mem_waddr != ZERO_ADDR);
        w_ex_hit1    = w_ex_writes  & id_rs1_used & (r_ex_waddr  == id_reg1_raddr);
        w_ex_hit2    = w_ex_writes  & id_rs2_used & (r_ex_waddr  == id_reg2_raddr);
        w_mem_hit1   = w_mem_writes & id_rs1_used & (r_mem_waddr == id_reg1_raddr);
        w_mem_hit2   = w_mem_writes & id_rs2_used & (r_mem_waddr == id_reg2_raddr);
    end

    // Forwarding selects; EX wins over MEM, but a load in EX has no result yet
    always_comb begin
        fwd1_sel = SEL_RF;
        fwd2_sel = SEL_RF;
        if (id_valid) begin
            if (w_ex_hit1 && !r_ex_is_load) begin
                fwd1_sel = SEL_EX;
            end else if (w_mem_hit1) begin
                fwd1_sel = SEL_MEM;
            end
            if (w_ex_hit2 && !r_ex_is_load) begin
                fwd2_sel = SEL_EX;
            end else if (w_mem_hit2) begin
                fwd2_sel = SEL_MEM;
            end
        end
    end

    // Load-use stall and bubble insertion; a redirected (killed) instruction never stalls
    always_comb begin
        w_stall  = id_valid & ~ex_redirect & r_ex_is_load & (w_ex_hit1 | w_ex_hit2);
        w_bubble = w_stall | ex_redirect | ~id_valid;
    end

    assign load_use_stall = w_stall;
    assign idex_bubble    = w_bubble;
    assign stall_cnt      = r_stall_cnt;

    // Slot advance: freeze on mem_busy, otherwise shift EX to MEM and load ID (or a bubble) into EX
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_waddr   <= '0;
            r_ex_we      <= 1'b0;
            r_ex_is_load <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_we     <= 1'b0;
        end else if (!mem_busy) begin
            r_mem_valid <= r_ex_valid;
            r_mem_waddr <= r_ex_waddr;
            r_mem_we    <= r_ex_we;
            if (w_bubble) begin
                r_ex_valid   <= 1'b0;
                r_ex_waddr   <= '0;
                r_ex_we      <= 1'b0;
                r_ex_is_load <= 1'b0;
            end else begin
                r_ex_valid   <= 1'b1;
                r_ex_waddr   <= id_reg_waddr;
                r_ex_we      <= id_reg_we;
                r_ex_is_load <= id_is_load;
            end
        end
    end

    // Stall cycle counter: one increment per cycle at most, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (mem_busy || w_stall) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - directed self-checking bench for id_hazard_scoreboard
module tb_id_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_reg1_raddr = '0;
    logic [4:0]  id_reg2_raddr = '0;
    logic        id_rs1_used = 1'b0;
    logic        id_rs2_used = 1'b0;
    logic [4:0]  id_reg_waddr = '0;
    logic        id_reg_we = 1'b0;
    logic        id_is_load = 1'b0;
    logic        ex_redirect = 1'b0;
    logic        mem_busy = 1'b0;
    logic [1:0]  fwd1_sel, fwd2_sel;
    logic        load_use_stall, idex_bubble;
    logic [31:0] stall_cnt;
    logic [1:0]  fwd1_sel_w, fwd2_sel_w;
    logic        load_use_stall_w, idex_bubble_w;
    logic [1:0]  stall_cnt_w;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_cnt = '0;

    always #5 clk = ~clk;

    id_hazard_scoreboard u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_reg1_raddr(id_reg1_raddr), .id_reg2_raddr(id_reg2_raddr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_reg_waddr(id_reg_waddr), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .load_use_stall(load_use_stall), .idex_bubble(idex_bubble), .stall_cnt(stall_cnt)
    );

    id_hazard_scoreboard #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) u_dut_w (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_reg1_raddr(id_reg1_raddr), .id_reg2_raddr(id_reg2_raddr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_reg_waddr(id_reg_waddr), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .fwd1_sel(fwd1_sel_w), .fwd2_sel(fwd2_sel_w),
        .load_use_stall(load_use_stall_w), .idex_bubble(idex_bubble_w), .stall_cnt(stall_cnt_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rd, input logic we, input logic ld,
                          input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        id_valid = 1'b1;
        id_reg_waddr = rd; id_reg_we = we; id_is_load = ld;
        id_reg1_raddr = rs1; id_rs1_used = u1;
        id_reg2_raddr = rs2; id_rs2_used = u2;
        #1;
    endtask

    task automatic flush();
        id_valid = 1'b0; id_reg_we = 1'b0; id_is_load = 1'b0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_redirect = 1'b0; mem_busy = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_busy = 1'b1;
        set_id(5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1);
        tick();
        n_total++; if (stall_cnt !== 32'd0) $display("FAIL reset_cnt got %0d want 0", stall_cnt); else n_pass++;
        n_total++; if (fwd1_sel !== 2'd0) $display("FAIL reset_fwd1 got %0d want 0", fwd1_sel); else n_pass++;
        n_total++; if (fwd2_sel !== 2'd0) $display("FAIL reset_fwd2 got %0d want 0", fwd2_sel); else n_pass++;
        n_total++; if (load_use_stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", load_use_stall); else n_pass++;
        n_total++; if (idex_bubble !== 1'b0) $display("FAIL reset_bubble got %0b want 0", idex_bubble); else n_pass++;
        tick();
        n_total++; if (stall_cnt !== 32'd0) $display("FAIL reset_cnt2 got %0d want 0", stall_cnt); else n_pass++;
        n_total++; if (stall_cnt_w !== 2'd0) $display("FAIL reset_cntw got %0d want 0", stall_cnt_w); else n_pass++;
        rst = 1'b0; mem_busy = 1'b0;
        exp_cnt = '0;
        flush();
    endtask

    task automatic test_alu_chain();
        flush();
        set_id(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        n_total++; if (fwd1_sel !== 2'd0) $display("FAIL alu_empty_fwd1 got %0d want 0", fwd1_sel); else n_pass++;
        tick();
        set_id(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1);
        n_total++; if (fwd1_sel !== 2'd1) $display("FAIL alu_d1_fwd1 got %0d want 1", fwd1_sel); else n_pass++;
        n_total++; if (fwd2_sel !== 2'd1) $display("FAIL alu_d1_fwd2 got %0d want 1", fwd2_sel); else n_pass++;
        n_total++; if (load_use_stall !== 1'b0) $display("FAIL alu_d1_stall got %0b want 0", load_use_stall); else n_pass++;
        n_total++; if (idex_bubble !== 1'b0) $display("FAIL alu_d1_bubble got %0b want 0", idex_bubble); else n_pass++;
        tick();
        set_id(5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b1);
        n_total++; if (fwd1_sel !== 2'd2) $display("FAIL alu_d2_fwd1 got %0d want 2", fwd1_sel); else n_pass++;
        n_total++; if (fwd2_sel !== 2'd0) $display("FAIL alu_d2_fwd2 got %0d want 0", fwd2_sel); else n_pass++;
        tick();
        set_id(5'd10, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1);
        n_total++; if (fwd1_sel !== 2'd0) $display("FAIL alu_d3_fwd1 got %0d want 0", fwd1_sel); else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        flush();
        set_id(5'd8, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd1, 1'b1);
        n_total++; if (load_use_stall !== 1'b1) $display("FAIL lu_stall got %0b want 1", load_use_stall); else n_pass++;
        n_total++; if (idex_bubble !== 1'b1) $display("FAIL lu_bubble got %0b want 1", idex_bubble); else n_pass++;
        tick();
        exp_cnt = exp_cnt + 1;
        n_total++; if (load_use_stall !== 1'b0) $display("FAIL lu_stall_after got %0b want 0", load_use_stall); else n_pass++;
        n_total++; if (idex_bubble !== 1'b0) $display("FAIL lu_bubble_after got %0b want 0", idex_bubble); else n_pass++;
        n_total++; if (fwd1_sel !== 2'd2) $display("FAIL lu_fwd1 got %0d want 2", fwd1_sel); else n_pass++;
        n_total++; if (fwd2_sel !== 2'd0) $display("FAIL lu_fwd2 got %0d want 0", fwd2_sel); else n_pass++;
        n_total++; if (stall_cnt !== exp_cnt) $display("FAIL lu_cnt got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
        n_total++; if (stall_cnt_w !== exp_cnt[1:0]) $display("FAIL lu_cntw got %0d want %0d", stall_cnt_w, exp_cnt[1:0]); else n_pass++;
        tick();
    endtask

    task automatic test_x0_unused();
        flush();
        set_id(5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(5'd1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        n_total++; if (fwd1_sel !== 2'd0) $display("FAIL x0_fwd1 got %0d want 0", fwd1_sel); else n_pass++;
        n_total++; if (fwd2_sel !== 2'd0) $display("FAIL x0_fwd2 got %0d want 0", fwd2_sel); else n_pass++;
        tick();
        set_id(5'd3, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(5'd4, 1'b1, 1'b0, 5'd3, 1'b0, 5'd3, 1'b0);
        n_total++; if (load_use_stall !== 1'b0) $display("FAIL unused_stall got %0b want 0", load_use_stall); else n_pass++;
        n_total++; if (fwd1_sel !== 2'd0) $display("FAIL unused_fwd1 got %0d want 0", fwd1_sel); else n_pass++;
        id_rs2_used = 1'b1;
        #1;
        n_total++; if (load_use_stall !== 1'b1) $display("FAIL used_rs2_stall got %0b want 1", load_use_stall); else n_pass++;
        id_valid = 1'b0;
        #1;
        n_total++; if (load_use_stall !== 1'b0) $display("FAIL novalid_stall got %0b want 0", load_use_stall); else n_pass++;
        n_total++; if (idex_bubble !== 1'b1) $display("FAIL novalid_bubble got %0b want 1", idex_bubble); else n_pass++;
        tick();
    endtask

    task automatic test_redirect();
        flush();
        set_id(5'd8, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
        ex_redirect = 1'b1;
        #1;
        n_total++; if (load_use_stall !== 1'b0) $display("FAIL redir_stall got %0b want 0", load_use_stall); else n_pass++;
        n_total++; if (idex_bubble !== 1'b1) $display("FAIL redir_bubble got %0b want 1", idex_bubble); else n_pass++;
        tick();
        ex_redirect = 1'b0;
        set_id(5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
        n_total++; if (load_use_stall !== 1'b0) $display("FAIL redir_next_stall got %0b want 0", load_use_stall); else n_pass++;
        n_total++; if (fwd1_sel !== 2'd2) $display("FAIL redir_next_fwd1 got %0d want 2", fwd1_sel); else n_pass++;
        n_total++; if (stall_cnt !== exp_cnt) $display("FAIL redir_cnt got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_mem_busy();
        flush();
        set_id(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (fwd1_sel !== 2'd1) $display("FAIL busy_fwd1_c%0d got %0d want 1", i, fwd1_sel); else n_pass++;
            tick();
            exp_cnt = exp_cnt + 1;
        end
        mem_busy = 1'b0;
        #1;
        n_total++; if (fwd1_sel !== 2'd1) $display("FAIL busy_release_fwd1 got %0d want 1", fwd1_sel); else n_pass++;
        n_total++; if (stall_cnt !== exp_cnt) $display("FAIL busy_cnt got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
        n_total++; if (stall_cnt_w !== exp_cnt[1:0]) $display("FAIL busy_cntw_wrap got %0d want %0d", stall_cnt_w, exp_cnt[1:0]); else n_pass++;
        tick();
        n_total++; if (fwd1_sel !== 2'd2) $display("FAIL busy_shift_fwd1 got %0d want 2", fwd1_sel); else n_pass++;
        tick();
    endtask

    task automatic test_busy_and_stall();
        flush();
        set_id(5'd8, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(5'd9, 1'b1, 1'b0, 5'd1, 1'b1, 5'd8, 1'b1);
        mem_busy = 1'b1;
        #1;
        n_total++; if (load_use_stall !== 1'b1) $display("FAIL bs_stall got %0b want 1", load_use_stall); else n_pass++;
        tick();
        exp_cnt = exp_cnt + 1;
        n_total++; if (stall_cnt !== exp_cnt) $display("FAIL bs_cnt_single got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
        mem_busy = 1'b0;
        #1;
        n_total++; if (load_use_stall !== 1'b1) $display("FAIL bs_stall_held got %0b want 1", load_use_stall); else n_pass++;
        tick();
        exp_cnt = exp_cnt + 1;
        n_total++; if (fwd2_sel !== 2'd2) $display("FAIL bs_fwd2 got %0d want 2", fwd2_sel); else n_pass++;
        n_total++; if (stall_cnt !== exp_cnt) $display("FAIL bs_cnt got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        flush();
        set_id(5'd8, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
        n_total++; if (load_use_stall !== 1'b1) $display("FAIL rms_pre_stall got %0b want 1", load_use_stall); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        #1;
        n_total++; if (load_use_stall !== 1'b0) $display("FAIL rms_stall got %0b want 0", load_use_stall); else n_pass++;
        n_total++; if (stall_cnt !== exp_cnt) $display("FAIL rms_cnt got %0d want 0", stall_cnt); else n_pass++;
        n_total++; if (fwd1_sel !== 2'd0) $display("FAIL rms_fwd1 got %0d want 0", fwd1_sel); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_x0_unused();
        test_redirect();
        test_mem_busy();
        test_busy_and_stall();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
